// File: rtl/three_phase_pwm.sv
// Three-phase centre-aligned PWM: one shared up/down carrier, double-buffered
// references, and an independent dead-time leg FSM per phase.
module three_phase_pwm #(
  parameter int CARRIER_MAX = 2000,
  parameter int DEADTIME    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ref_valid,
  input  logic [15:0] ref1,
  input  logic [15:0] ref2,
  input  logic [15:0] ref3,
  output logic [2:0]  gate_h,
  output logic [2:0]  gate_l,
  output logic        period_start
);

  localparam logic [15:0] CNT_MAX     = 16'(CARRIER_MAX);
  localparam logic [7:0]  DEAD_CYCLES = 8'(DEADTIME);

  typedef enum logic [1:0] {
    LEG_OFF,
    LEG_HI,
    LEG_LO,
    LEG_DEAD
  } leg_state_t;

  logic        armed;
  logic        run;
  logic        at_zero;
  logic [15:0] cnt;
  logic        cnt_up;

  logic [15:0] shadow_ref [3];
  logic [15:0] act_ref    [3];
  logic [2:0]  cmp;

  leg_state_t  leg_state    [3];
  leg_state_t  leg_state_nx [3];
  logic [2:0]  target;
  logic [2:0]  target_nx;
  logic [7:0]  dead_cnt     [3];
  logic [7:0]  dead_cnt_nx  [3];
  logic [2:0]  gate_h_nx;
  logic [2:0]  gate_l_nx;

  // Reset release is taken through one flop, so the first enabled cycle is
  // the one after the first clock edge following release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign run     = en & armed;
  assign at_zero = run && (cnt == 16'd0);

  // NOTE: every clocked block uses non-blocking assignments so all flops see
  // the pre-edge values of each other, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 16'd0;
      cnt_up <= 1'b1;
    end else if (!run) begin
      cnt    <= 16'd0;
      cnt_up <= 1'b1;
    end else if (cnt_up) begin
      cnt <= cnt + 16'd1;
      if (cnt == CNT_MAX - 16'd1) cnt_up <= 1'b0;
    end else begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1) cnt_up <= 1'b1;
    end
  end

  // NOTE: the reference registers are cleared with the rest of the state so a
  // stale sample can never reach a gate after reset.
  // A strobe on the load cycle lands in the shadow at the same edge the active
  // copy reads the shadow, so the active copy takes the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        shadow_ref[i] <= 16'd0;
        act_ref[i]    <= 16'd0;
      end
      period_start <= 1'b0;
    end else begin
      if (ref_valid) begin
        shadow_ref[0] <= ref1;
        shadow_ref[1] <= ref2;
        shadow_ref[2] <= ref3;
      end
      if (at_zero) begin
        for (int i = 0; i < 3; i++) act_ref[i] <= shadow_ref[i];
      end
      period_start <= at_zero;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) cmp[i] = (act_ref[i] > cnt);
  end

  // NOTE: every output of this block is given a default before any branch, so
  // no path can leave a value unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      leg_state_nx[i] = leg_state[i];
      target_nx[i]    = target[i];
      dead_cnt_nx[i]  = dead_cnt[i];

      if (!run) begin
        leg_state_nx[i] = LEG_OFF;
      end else begin
        unique case (leg_state[i])
          LEG_OFF: begin
            leg_state_nx[i] = LEG_DEAD;
            target_nx[i]    = cmp[i];
            dead_cnt_nx[i]  = DEAD_CYCLES;
          end
          LEG_HI: begin
            if (!cmp[i]) begin
              leg_state_nx[i] = LEG_DEAD;
              target_nx[i]    = 1'b0;
              dead_cnt_nx[i]  = DEAD_CYCLES;
            end
          end
          LEG_LO: begin
            if (cmp[i]) begin
              leg_state_nx[i] = LEG_DEAD;
              target_nx[i]    = 1'b1;
              dead_cnt_nx[i]  = DEAD_CYCLES;
            end
          end
          LEG_DEAD: begin
            if (cmp[i] != target[i]) begin
              target_nx[i]   = cmp[i];
              dead_cnt_nx[i] = DEAD_CYCLES;
            end else if (dead_cnt[i] == 8'd0) begin
              leg_state_nx[i] = target[i] ? LEG_HI : LEG_LO;
            end else begin
              dead_cnt_nx[i] = dead_cnt[i] - 8'd1;
            end
          end
          default: leg_state_nx[i] = LEG_OFF;
        endcase
      end

      gate_h_nx[i] = (leg_state_nx[i] == LEG_HI);
      gate_l_nx[i] = (leg_state_nx[i] == LEG_LO);
    end
  end

  // Gates are flopped from the next state so they line up with the state
  // register; HI and LO are exclusive, so one leg can never drive both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        leg_state[i] <= LEG_OFF;
        dead_cnt[i]  <= 8'd0;
      end
      target <= 3'b000;
      gate_h <= 3'b000;
      gate_l <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        leg_state[i] <= leg_state_nx[i];
        dead_cnt[i]  <= dead_cnt_nx[i];
      end
      target <= target_nx;
      gate_h <= gate_h_nx;
      gate_l <= gate_l_nx;
    end
  end

endmodule

// File: tb/tb_three_phase_pwm.sv
// Scoreboard bench for three_phase_pwm: a behavioural model predicts gates and
// period_start per cycle; a monitor compares them on the falling clock edge.
module tb_three_phase_pwm;

  localparam int CMAX = 8;
  localparam int DT   = 2;
  localparam int PER  = 2 * CMAX;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        en        = 1'b0;
  logic        ref_valid = 1'b0;
  logic [15:0] ref1      = 16'd0;
  logic [15:0] ref2      = 16'd0;
  logic [15:0] ref3      = 16'd0;
  logic [2:0]  gate_h;
  logic [2:0]  gate_l;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  three_phase_pwm #(
    .CARRIER_MAX(CMAX),
    .DEADTIME   (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ref_valid   (ref_valid),
    .ref1        (ref1),
    .ref2        (ref2),
    .ref3        (ref3),
    .gate_h      (gate_h),
    .gate_l      (gate_l),
    .period_start(period_start)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] l;
    logic       ps;
  } exp_t;

  exp_t q[$];

  // Model: carrier position as a plain index into a 2*CMAX period; a leg drives
  // the side matching cmp once cmp has held one value for DT+2 enabled cycles.
  bit          m_armed = 1'b0;
  int          m_pos   = 0;
  logic [15:0] m_shadow [3] = '{16'd0, 16'd0, 16'd0};
  logic [15:0] m_act    [3] = '{16'd0, 16'd0, 16'd0};
  int          m_streak [3] = '{0, 0, 0};
  bit          m_last   [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    exp_t        e;
    bit          run;
    bit          cv;
    int          c;
    logic [15:0] refs [3];
    e = '0;
    if (!rst_n) begin
      m_armed = 1'b0;
      m_pos   = 0;
      for (int k = 0; k < 3; k++) begin
        m_shadow[k] = 16'd0;
        m_act[k]    = 16'd0;
        m_streak[k] = 0;
        m_last[k]   = 1'b0;
      end
    end else begin
      run  = en && m_armed;
      c    = (m_pos <= CMAX) ? m_pos : PER - m_pos;
      refs = '{ref1, ref2, ref3};
      for (int k = 0; k < 3; k++) begin
        if (run) begin
          cv = (int'(m_act[k]) > c);
          if (m_streak[k] == 0 || cv != m_last[k]) begin
            m_last[k]   = cv;
            m_streak[k] = 1;
          end else if (m_streak[k] < 1000) begin
            m_streak[k]++;
          end
          if (m_streak[k] >= DT + 2) begin
            e.h[k] = cv;
            e.l[k] = !cv;
          end
        end else begin
          m_streak[k] = 0;
        end
      end
      e.ps = run && (c == 0);
      if (run && c == 0) m_act = m_shadow;
      if (ref_valid) m_shadow = refs;
      m_pos   = run ? (m_pos + 1) % PER : 0;
      m_armed = 1'b1;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    check("no_overlap", int'(gate_h & gate_l), 0);
    if (!rst_n) begin
      q.delete();
      check("in_reset_gate_h", int'(gate_h), 0);
      check("in_reset_gate_l", int'(gate_l), 0);
      check("in_reset_period_start", int'(period_start), 0);
    end else if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: no expectation queued (t=%0t)", $time);
    end else begin
      e = q.pop_front();
      check("gate_h", int'(gate_h), int'(e.h));
      check("gate_l", int'(gate_l), int'(e.l));
      check("period_start", int'(period_start), int'(e.ps));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_refs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    ref1      = a;
    ref2      = b;
    ref3      = c;
    ref_valid = 1'b1;
    step(1);
    ref_valid = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_gate_h", int'(gate_h), 0);
    check("async_rst_gate_l", int'(gate_l), 0);
    check("async_rst_period_start", int'(period_start), 0);
    check("async_rst_cnt", int'(dut.cnt), 0);
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ps(input string name);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 64) begin
      @(negedge clk);
      n++;
      if (period_start) found = 1'b1;
    end
    check(name, int'(found), 1);
  endtask

  int mh [3];
  int ml [3];
  int mb [3];

  task automatic measure();
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0;
      ml[k] = 0;
      mb[k] = 0;
    end
    repeat (PER) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        mh[k] += int'(gate_h[k]);
        ml[k] += int'(gate_l[k]);
        mb[k] += int'(!gate_h[k] && !gate_l[k]);
      end
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'd0;
      1:       return 16'($urandom_range(0, CMAX + 1));
      2:       return 16'hFFFF;
      3:       return 16'($urandom);
      default: return 16'(CMAX);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    step(3);
    check("reset_cnt", int'(dut.cnt), 0);
    check("reset_gate_h", int'(gate_h), 0);
    check("reset_gate_l", int'(gate_l), 0);

    // Release with enable and a first sample: carrier moves on the 2nd edge.
    rst_n     = 1'b1;
    en        = 1'b1;
    ref1      = 16'd4;
    ref2      = 16'd2;
    ref3      = 16'd6;
    ref_valid = 1'b1;
    step(1);
    ref_valid = 1'b0;
    check("cnt_after_edge1", int'(dut.cnt), 0);
    step(1);
    check("cnt_after_edge2", int'(dut.cnt), 1);

    // Steady state with refs 4 / 2 / 6 on an 8-peak carrier.
    step(40);
    measure();
    check("ref4_high", mh[0], 4);
    check("ref4_low", ml[0], 6);
    check("ref4_both_off", mb[0], 6);
    check("ref2_high", mh[1], 0);
    check("ref2_low", ml[1], 10);
    check("ref6_high", mh[2], 8);
    check("ref6_low", ml[2], 2);
    check("ref6_both_off", mb[2], 6);

    // Saturated references.
    load_refs(16'd0, 16'd9, 16'hFFFF);
    step(40);
    measure();
    check("ref0_low", ml[0], PER);
    check("ref9_high", mh[1], PER);
    check("ref65535_high", mh[2], PER);

    // Reset while the upper legs are on.
    step(1);
    check("hi_before_reset", int'(gate_h[2]), 1);
    do_reset();
    load_refs(16'd8, 16'd4, 16'd12);
    step(40);
    measure();
    check("ref8_no_low", ml[0], 0);
    check("ref4b_high", mh[1], 4);
    check("ref12_high", mh[2], PER);

    // Period spacing, and a sample arriving mid-period.
    wait_ps("ps_found");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 64);
    check("period_len", n, PER);
    step(5);
    load_refs(16'd4, 16'd4, 16'd4);
    wait_ps("ps_found_2");
    wait_ps("ps_found_3");

    // Sample strobed on the load cycle itself must wait a full period.
    step(15);
    load_refs(16'd12, 16'd12, 16'd12);
    measure();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("coincident_old_high_p%0d", k + 1), mh[k], 4);
      check($sformatf("coincident_old_low_p%0d", k + 1), ml[k], 6);
    end

    // Enable drop mid-period and re-enable.
    step(21);
    en = 1'b0;
    step(1);
    check("en_off_gate_h", int'(gate_h), 0);
    check("en_off_gate_l", int'(gate_l), 0);
    check("en_off_cnt", int'(dut.cnt), 0);
    step(3);
    en = 1'b1;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((gate_h | gate_l) != 3'b000) break;
      n++;
    end
    check("en_rise_dead_cycles", n, DT + 1);
    check("en_rise_side", int'(gate_h), 7);

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 79) == 0) en = ~en;
      if ($urandom_range(0, 5) == 0) begin
        ref1      = pick();
        ref2      = pick();
        ref3      = pick();
        ref_valid = 1'b1;
      end else begin
        ref_valid = 1'b0;
      end
      step(1);
    end
    ref_valid = 1'b0;
    en        = 1'b1;
    step(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
